// File: rtl/crypto_path_sequencer_pkg.sv
// Shared types for the RSA path sequencer: widths, path FSM states, side-FIFO entry.
package crypto_pkg;

  localparam int DEF_MSG_W = 64;
  localparam int DEF_HDR_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOADED     = 2'b01,
    RUN        = 2'b10,
    RUN_LOADED = 2'b11
  } path_state_t;

  typedef struct packed {
    logic [DEF_HDR_W-1:0] hdr;
    logic [DEF_MSG_W-1:0] raw;
  } side_entry_t;

  function automatic logic is_loaded(input path_state_t s);
    return (s == LOADED) || (s == RUN_LOADED);
  endfunction

  function automatic logic is_running(input path_state_t s);
    return (s == RUN) || (s == RUN_LOADED);
  endfunction

endpackage

// File: rtl/crypto_path_sequencer_side_fifo.sv
// Small synchronous FIFO carrying {hdr, raw} past the engine.
module side_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic [WIDTH-1:0] rdata_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_out  = (cnt_q == DEPTH[AW:0]);
  assign empty_out = (cnt_q == '0);
  assign do_push   = push_in & ~full_out;
  assign do_pop    = pop_in & ~empty_out;
  assign rdata_out = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q] <= wdata_in;
  end

endmodule

// File: rtl/crypto_path_sequencer.sv
// NUM_PATHS independent src -> mod_exponent -> sink paths.
// Optional PATH_STATS_EN adds per-path sink handshake counters.
module crypto_path_sequencer
  import crypto_pkg::*;
#(
  parameter int MSG_W      = DEF_MSG_W,
  parameter int HDR_W      = DEF_HDR_W,
  parameter int NUM_PATHS  = 2,
  parameter int SIDE_DEPTH = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       setup_done_in,
  input  logic [NUM_PATHS-1:0]       src_valid_in,
  output logic [NUM_PATHS-1:0]       src_ready_out,
  input  logic [NUM_PATHS*MSG_W-1:0] src_msg_in,
  input  logic [NUM_PATHS*HDR_W-1:0] src_hdr_in,
  output logic [NUM_PATHS-1:0]       eng_start_out,
  output logic [NUM_PATHS*MSG_W-1:0] eng_msg_out,
  input  logic [NUM_PATHS-1:0]       eng_busy_in,
  input  logic [NUM_PATHS-1:0]       eng_done_in,
  input  logic [NUM_PATHS*MSG_W-1:0] eng_res_in,
  output logic [NUM_PATHS-1:0]       eng_ready_out,
  output logic [NUM_PATHS-1:0]       snk_valid_out,
  input  logic [NUM_PATHS-1:0]       snk_ready_in,
  output logic [NUM_PATHS*MSG_W-1:0] snk_res_out,
  output logic [NUM_PATHS*MSG_W-1:0] snk_raw_out,
  output logic [NUM_PATHS*HDR_W-1:0] snk_hdr_out,
  output logic [NUM_PATHS-1:0]       err_out
`ifdef PATH_STATS_EN
  ,
  output logic [NUM_PATHS*16-1:0]    stat_cnt_out
`endif
);

  localparam int EW = HDR_W + MSG_W;

  for (genvar p = 0; p < NUM_PATHS; p++) begin : g_path
    path_state_t      state_q, state_d;
    logic [MSG_W-1:0] in_msg_q, res_q, raw_q;
    logic [HDR_W-1:0] hdr_q;
    logic             snk_valid_q, err_q;
    logic [EW-1:0]    fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             in_valid, inflight;
    logic             accept, issue, finish, fill, drain;

    assign in_valid = is_loaded(state_q);
    assign inflight = is_running(state_q);

    assign src_ready_out[p] = setup_done_in & ~in_valid & ~fifo_full;
    assign accept = src_valid_in[p] & src_ready_out[p];
    assign issue  = in_valid & ~inflight & ~eng_busy_in[p];
    assign eng_ready_out[p] = ~snk_valid_q | snk_ready_in[p];
    assign finish = eng_done_in[p] & eng_ready_out[p];
    assign fill   = finish & ~fifo_empty;
    assign drain  = snk_valid_q & snk_ready_in[p];

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:       if (accept) state_d = LOADED;
        LOADED:     if (issue) state_d = RUN;
        RUN: begin
          if (finish)      state_d = accept ? LOADED : IDLE;
          else if (accept) state_d = RUN_LOADED;
        end
        RUN_LOADED: if (finish) state_d = LOADED;
        default:    state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        state_q     <= IDLE;
        in_msg_q    <= '0;
        res_q       <= '0;
        raw_q       <= '0;
        hdr_q       <= '0;
        snk_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        state_q <= state_d;
        if (accept) in_msg_q <= src_msg_in[p*MSG_W +: MSG_W];
        if (fill) begin
          res_q          <= eng_res_in[p*MSG_W +: MSG_W];
          {hdr_q, raw_q} <= fifo_rdata;
          snk_valid_q    <= 1'b1;
        end else if (drain) begin
          snk_valid_q <= 1'b0;
        end
        // A result with no matching side entry is unrecoverable
        if (finish & fifo_empty) err_q <= 1'b1;
      end
    end

    side_fifo #(
      .WIDTH (EW),
      .DEPTH (SIDE_DEPTH)
    ) u_side (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_in   (accept),
      .pop_in    (finish),
      .wdata_in  ({src_hdr_in[p*HDR_W +: HDR_W],
                   src_msg_in[p*MSG_W +: MSG_W]}),
      .rdata_out (fifo_rdata),
      .full_out  (fifo_full),
      .empty_out (fifo_empty)
    );

    assign eng_start_out[p]              = issue;
    assign eng_msg_out[p*MSG_W +: MSG_W] = in_msg_q;
    assign snk_valid_out[p]              = snk_valid_q;
    assign snk_res_out[p*MSG_W +: MSG_W] = res_q;
    assign snk_raw_out[p*MSG_W +: MSG_W] = raw_q;
    assign snk_hdr_out[p*HDR_W +: HDR_W] = hdr_q;
    assign err_out[p]                    = err_q;

`ifdef PATH_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)     stat_q <= '0;
      else if (drain) stat_q <= stat_q + 16'd1;
    end
    assign stat_cnt_out[p*16 +: 16] = stat_q;
`endif
  end

endmodule

// File: tb/tb_crypto_path_sequencer.sv
// Scoreboard bench for crypto_path_sequencer with a behavioural engine per path.
module tb_crypto_path_sequencer;

  localparam int P  = 2;
  localparam int MW = 64;
  localparam int HW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            setup = 1'b0;
  logic [P-1:0]    src_valid = '0;
  logic [P-1:0]    src_ready, eng_start, eng_busy, eng_done;
  logic [P-1:0]    eng_ready, snk_valid, err;
  logic [P-1:0]    snk_ready = '1;
  logic [P*MW-1:0] src_msg = '0;
  logic [P*HW-1:0] src_hdr = '0;
  logic [P*MW-1:0] eng_msg, eng_res, snk_res, snk_raw;
  logic [P*HW-1:0] snk_hdr;
`ifdef PATH_STATS_EN
  logic [P*16-1:0] stat;
`endif

  always #5 clk = ~clk;

  crypto_path_sequencer dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .setup_done_in (setup),
    .src_valid_in  (src_valid),
    .src_ready_out (src_ready),
    .src_msg_in    (src_msg),
    .src_hdr_in    (src_hdr),
    .eng_start_out (eng_start),
    .eng_msg_out   (eng_msg),
    .eng_busy_in   (eng_busy),
    .eng_done_in   (eng_done),
    .eng_res_in    (eng_res),
    .eng_ready_out (eng_ready),
    .snk_valid_out (snk_valid),
    .snk_ready_in  (snk_ready),
    .snk_res_out   (snk_res),
    .snk_raw_out   (snk_raw),
    .snk_hdr_out   (snk_hdr),
    .err_out       (err)
`ifdef PATH_STATS_EN
    ,
    .stat_cnt_out  (stat)
`endif
  );

  // Engine model: result = bitwise NOT of the operand, 10 cycles after start
  logic [P-1:0]  e_busy, e_done;
  logic [P-1:0]  spur = '0;
  logic [MW-1:0] e_res [P];
  int            e_cnt [P];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_busy <= '0;
      e_done <= '0;
      for (int p = 0; p < P; p++) begin
        e_cnt[p] <= 0;
        e_res[p] <= '0;
      end
    end else begin
      for (int p = 0; p < P; p++) begin
        if (e_done[p]) begin
          if (eng_ready[p]) e_done[p] <= 1'b0;
        end else if (e_busy[p]) begin
          if (e_cnt[p] == 1) begin
            e_busy[p] <= 1'b0;
            e_done[p] <= 1'b1;
          end else begin
            e_cnt[p] <= e_cnt[p] - 1;
          end
        end else if (eng_start[p]) begin
          e_busy[p] <= 1'b1;
          e_cnt[p]  <= 10;
          e_res[p]  <= ~eng_msg[p*MW +: MW];
        end
      end
    end
  end

  assign eng_busy = e_busy;
  assign eng_done = e_done | spur;
  for (genvar g = 0; g < P; g++) begin : g_res
    assign eng_res[g*MW +: MW] = e_res[g];
  end

  typedef struct {
    logic [MW-1:0] msg;
    logic [HW-1:0] hdr;
    logic [MW-1:0] res;
  } vec_t;

  vec_t V [8] = '{
    '{64'h0001020304050607, 32'h3F800007, 64'hFFFEFDFCFBFAF9F8},
    '{64'h1111111111111111, 32'h00000011, 64'hEEEEEEEEEEEEEEEE},
    '{64'hFFFFFFFFFFFFFFFF, 32'h00000022, 64'h0000000000000000},
    '{64'h0000000000000000, 32'h00000033, 64'hFFFFFFFFFFFFFFFF},
    '{64'h123456789ABCDEF0, 32'h00000044, 64'hEDCBA9876543210F},
    '{64'hA5A5A5A5A5A5A5A5, 32'h00000055, 64'h5A5A5A5A5A5A5A5A},
    '{64'h8000000000000001, 32'h00000066, 64'h7FFFFFFFFFFFFFFE},
    '{64'hDEADBEEFCAFEF00D, 32'h00000077, 64'h2152411035010FF2}
  };

  typedef struct {
    logic [MW-1:0] res;
    logic [MW-1:0] raw;
    logic [HW-1:0] hdr;
  } exp_t;

  exp_t sb0 [$];
  exp_t sb1 [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sb_push(input int p, input int v);
    exp_t e;
    e.res = V[v].res;
    e.raw = V[v].msg;
    e.hdr = V[v].hdr;
    if (p == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic int sb_size(input int p);
    return (p == 0) ? sb0.size() : sb1.size();
  endfunction

  // Monitor: every sink handshake pops and compares one expected entry
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < P; p++) begin
        if (snk_valid[p] && snk_ready[p]) begin
          exp_t e;
          if (sb_size(p) == 0) begin
            check($sformatf("p%0d_unexpected_out", p), 1, 0);
          end else begin
            if (p == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("p%0d_res", p), snk_res[p*MW +: MW], e.res);
            check($sformatf("p%0d_raw", p), snk_raw[p*MW +: MW], e.raw);
            check($sformatf("p%0d_hdr", p), snk_hdr[p*HW +: HW], e.hdr);
          end
        end
      end
    end
  end

  // Called and returns at posedge+1
  task automatic send(input int p, input int v);
    bit ok;
    ok = 0;
    src_msg[p*MW +: MW] = V[v].msg;
    src_hdr[p*HW +: HW] = V[v].hdr;
    src_valid[p] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (src_ready[p]) begin
        sb_push(p, v);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    src_valid[p] = 1'b0;
    check($sformatf("p%0d_send_accept", p), ok, 1);
  endtask

  task automatic wait_drain(input int p, input int limit);
    for (int i = 0; i < limit && sb_size(p) != 0; i++) begin
      @(posedge clk); #1;
    end
    check($sformatf("p%0d_drain", p), sb_size(p), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int  cnt_a, cnt_b;
  bit  seen;
  logic [MW-1:0] h_res, h_raw;
  logic [HW-1:0] h_hdr;

  initial begin
    #1;
    check("rst_eng_ready", eng_ready, 2'b11);
    check("rst_snk_valid", snk_valid, 2'b00);
    check("rst_eng_start", eng_start, 2'b00);
    check("rst_err", err, 2'b00);
    check("rst_src_ready", src_ready, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: no setup, no accept
    src_msg[0 +: MW] = V[0].msg;
    src_hdr[0 +: HW] = V[0].hdr;
    src_valid[0] = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (src_ready[0]) cnt_a++;
      if (eng_start[0]) cnt_b++;
    end
    @(posedge clk); #1;
    src_valid[0] = 1'b0;
    check("t1_no_ready", cnt_a, 0);
    check("t1_no_start", cnt_b, 0);

    // 2: single word, start latency and done->valid latency
    setup = 1'b1;
    src_valid[0] = 1'b1;
    @(negedge clk);
    check("t2_ready", src_ready[0], 1'b1);
    sb_push(0, 0);
    @(posedge clk); #1;
    src_valid[0] = 1'b0;
    @(negedge clk);
    check("t2_start_t_plus_1", eng_start[0], 1'b1);
    check("t2_eng_msg", eng_msg[0 +: MW], V[0].msg);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (eng_done[0]) seen = 1;
    end
    check("t2_done_seen", seen, 1);
    check("t2_valid_not_early", snk_valid[0], 1'b0);
    @(negedge clk);
    check("t2_valid_after_done", snk_valid[0], 1'b1);
    @(posedge clk); #1;
    wait_drain(0, 20);

    // 3: second word buffered while engine runs
    send(0, 1);
    send(0, 2);
    @(negedge clk);
    check("t3_held_not_ready", src_ready[0], 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (eng_start[0]) seen = 1;
    end
    check("t3_second_issue", seen, 1);
    @(posedge clk); #1;
    wait_drain(0, 60);

    // 4: sink stall holds data and backpressures the engine
    snk_ready[0] = 1'b0;
    send(0, 3);
    send(0, 4);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (snk_valid[0]) seen = 1;
    end
    check("t4_result_held", seen, 1);
    h_res = snk_res[0 +: MW];
    h_raw = snk_raw[0 +: MW];
    h_hdr = snk_hdr[0 +: HW];
    check("t4_held_res", h_res, V[3].res);
    cnt_a = 0;
    repeat (20) begin
      @(negedge clk);
      if (eng_ready[0] || !snk_valid[0] || snk_res[0 +: MW] != h_res ||
          snk_raw[0 +: MW] != h_raw || snk_hdr[0 +: HW] != h_hdr)
        cnt_a++;
    end
    check("t4_stall_stable", cnt_a, 0);
    check("t4_done_pending", eng_done[0], 1'b1);
    @(posedge clk); #1;
    snk_ready[0] = 1'b1;
    wait_drain(0, 60);

    // 5: path0 stalled, path1 streams four words
    snk_ready[0] = 1'b0;
    send(0, 5);
    send(1, 0);
    send(1, 1);
    send(1, 2);
    send(1, 3);
    wait_drain(1, 100);
    check("t5_p0_still_held", sb_size(0), 1);
    check("t5_p0_valid", snk_valid[0], 1'b1);
    snk_ready[0] = 1'b1;
    wait_drain(0, 60);

    // 6: async reset mid-job, then a spurious done
    send(0, 6);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (eng_busy[0]) seen = 1;
    end
    check("t6_running", seen, 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_snk_valid", snk_valid, 2'b00);
    check("t6_rst_eng_start", eng_start, 2'b00);
    check("t6_rst_eng_ready", eng_ready, 2'b11);
    check("t6_rst_eng_msg", eng_msg[0 +: MW], 64'h0);
    check("t6_rst_err", err, 2'b00);
    sb0.delete();
    sb1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    spur[1] = 1'b1;
    @(posedge clk); #1;
    spur[1] = 1'b0;
    @(negedge clk);
    check("t6_err_set", err, 2'b10);
    check("t6_result_dropped", snk_valid[1], 1'b0);
    @(posedge clk); #1;
    send(1, 7);
    wait_drain(1, 60);
    check("t6_err_sticky", err, 2'b10);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
